compare_iter: RTL and testbench
===============================

Name: compare_iter

Overview:
- Multi-cycle, parametrised three-way comparator (greater, equal, less) for WIDTH-bit operands, in signed or unsigned mode selectable per operation.
- Compares CHUNK bits per cycle, MSB chunk first, under a valid/ready handshake on both input and output.
- Sits beside the branch-condition path, where area matters more than latency: wide compares for branch resolution and bounds checks.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per RUN cycle; CHUNK == WIDTH gives single-cycle compare.
- NCHUNK, WIDTH/CHUNK, derived localparam; not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation (IDLE only).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- is_signed  in  1  1 = two's-complement compare; 0 = unsigned.
- out_valid  out  1  result flags valid.
- out_ready  in  1  consumer accepts result.
- AgtB  out  1  A > B.
- AeqB  out  1  A == B.
- AltB  out  1  A < B.

Behaviour:
- Reset (async, active-high, one clock, clk): state IDLE; in_ready=1 after release; out_valid=0; AgtB=AeqB=AltB=0; chunk index and operand registers cleared.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge: capture a, b, is_signed; set idx=NCHUNK-1; set decided=0 and the working result to equal; go to RUN.
  - Signed mode: invert bit WIDTH-1 of both captured operands, so an unsigned compare yields the signed order.
- RUN:
  - in_ready=0.
  - Each cycle, chunk idx of A is compared unsigned against chunk idx of B.
  - If not yet decided and the chunks differ: record gt or lt and set decided=1.
  - Later chunks never overwrite a decided result.
  - Leave RUN to DONE when idx==0, or when early exit applies (see Optional Feature); otherwise decrement idx.
- DONE:
  - out_valid=1; exactly one of AgtB/AeqB/AltB is 1. AeqB=1 only if all chunks matched.
  - Flags and out_valid hold stable while out_ready=0.
  - On out_valid && out_ready: go to IDLE and drop out_valid.
  - Flags keep their last value until the next result is loaded.
- Latency, accept edge to out_valid high:
  - Without early exit: exactly NCHUNK+1 cycles.
  - With early exit: k+1 cycles, where k = 1 + (number of leading equal chunks), capped at NCHUNK.
- No overlap: a new operation is accepted one cycle after output handshake at the earliest. in_valid outside IDLE is ignored; the requester must hold it.
- Operands that change after capture have no effect.
- Reset mid-RUN or mid-DONE aborts immediately; no result is emitted.

Optional Feature:
- Macro: COMPARE_ITER_EARLY_EXIT_EN.
- Defined: RUN exits to DONE in the same cycle a differing chunk is found, so latency is data-dependent.
- Undefined: RUN always runs all NCHUNK cycles and the decision is sticky, giving fixed, data-independent latency (timing-safe). Flag values are identical either way.

Decomposition:
- Package compare_pkg:
  - cmp_state_e enum (IDLE, RUN, DONE).
  - cmp_result_t packed struct {gt, eq, lt}.
  - Constants CMP_GT, CMP_EQ, CMP_LT.
- One sub-module, compare_chunk: combinational, CHUNK-bit unsigned three-way compare returning cmp_result_t. Instantiated once and fed by a mux on idx.

Test Plan:
- WIDTH=32, CHUNK=8, unsigned: a=0x8000_0000, b=0x7FFF_FFFF -> AgtB=1. With early exit: out_valid 2 cycles after accept. Without: 5 cycles.
- Same operands, is_signed=1 -> AltB=1 (MIN_INT < MAX_INT); flag values identical with and without early exit.
- a=b=0x1234_5678, both modes -> AeqB=1, others 0; out_valid 5 cycles after accept in both builds.
- Signed: a=0xFFFF_FFFE (-2), b=0xFFFF_FFFF (-1) -> AltB=1, 5 cycles (differs in chunk 0). Unsigned with the same operands -> AltB=1.
- Hold out_ready=0 for 5 cycles in DONE while toggling in_valid with new operands -> flags and out_valid stable, in_ready=0. Release out_ready -> IDLE, in_ready=1 next cycle, then the new op is accepted.
- Assert rst asynchronously during the second RUN cycle -> out_valid=0 and all flags 0 immediately. After release, in_ready=1 and a fresh compare (a=5, b=3) -> AgtB=1.

Source files
------------

// File: rtl/compare_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// compare_pkg : shared types and constants for the iterative comparator
// Revision    : 1.0
// ----------------------------------------------------------------------------
package compare_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_result_t;

  localparam cmp_result_t CMP_GT = cmp_result_t'(3'b100);
  localparam cmp_result_t CMP_EQ = cmp_result_t'(3'b010);
  localparam cmp_result_t CMP_LT = cmp_result_t'(3'b001);

endpackage
`default_nettype wire

// File: rtl/compare_chunk.sv
`default_nettype none
// ----------------------------------------------------------------------------
// compare_chunk : combinational CHUNK-bit unsigned three-way compare
// Revision      : 1.0
// ----------------------------------------------------------------------------
module compare_chunk
  import compare_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output cmp_result_t      res_o
);

  always_comb begin
    res_o = CMP_EQ;
    if (a_i > b_i) begin
      res_o = CMP_GT;
    end else if (a_i < b_i) begin
      res_o = CMP_LT;
    end
  end

endmodule
`default_nettype wire

// File: rtl/compare_iter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// compare_iter : multi-cycle signed/unsigned three-way comparator, MSB chunk
//                first. COMPARE_ITER_EARLY_EXIT_EN ends RUN on first difference.
// Revision     : 1.0
// ----------------------------------------------------------------------------
module compare_iter
  import compare_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             AgtB,
  output logic             AeqB,
  output logic             AltB
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0]  LAST_IDX  = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

  cmp_state_e       state_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             decided_q;
  cmp_result_t      res_q, flags_q;
  logic             in_ready_q, out_valid_q;

  logic [CHUNK-1:0] chunk_a, chunk_b;
  cmp_result_t      chunk_res, res_d;
  logic             decided_d, early_exit;

  assign chunk_a = a_q[idx_q*CHUNK +: CHUNK];
  assign chunk_b = b_q[idx_q*CHUNK +: CHUNK];

  compare_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i   (chunk_a),
    .b_i   (chunk_b),
    .res_o (chunk_res)
  );

  // Once a differing chunk is seen, lower chunks cannot change the outcome.
  assign res_d     = decided_q ? res_q : chunk_res;
  assign decided_d = decided_q | ~chunk_res.eq;

`ifdef COMPARE_ITER_EARLY_EXIT_EN
  assign early_exit = ~decided_q & ~chunk_res.eq;
`else
  assign early_exit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      decided_q   <= 1'b0;
      res_q       <= CMP_EQ;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Flipping the sign bits maps two's-complement order onto unsigned order.
            a_q        <= a ^ (is_signed ? SIGN_MASK : '0);
            b_q        <= b ^ (is_signed ? SIGN_MASK : '0);
            idx_q      <= LAST_IDX;
            decided_q  <= 1'b0;
            res_q      <= CMP_EQ;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          res_q     <= res_d;
          decided_q <= decided_d;
          if (idx_q == '0 || early_exit) begin
            flags_q <= res_d;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q - IDXW'(1);
          end
        end
        DONE: begin
          // out_valid rises one cycle after entry, after the flags have settled.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign AgtB      = flags_q.gt;
  assign AeqB      = flags_q.eq;
  assign AltB      = flags_q.lt;

endmodule
`default_nettype wire

// File: tb/tb_compare_iter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_compare_iter : randomized + directed self-checking bench for compare_iter
// Revision        : 1.0
// ----------------------------------------------------------------------------
module tb_compare_iter;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;
`ifdef COMPARE_ITER_EARLY_EXIT_EN
  localparam int LAT_TOPDIFF = 2;
`else
  localparam int LAT_TOPDIFF = 5;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             is_signed = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             AgtB, AeqB, AltB;

  int          vectors = 0;
  int          miscompares = 0;
  logic [2:0]  cur_exp = '0;
  logic        cur_valid = 1'b0;

  compare_iter #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .AgtB      (AgtB),
    .AeqB      (AeqB),
    .AltB      (AltB)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: flags straight from arithmetic order of the operand values.
  function automatic logic [2:0] model_flags(input logic [31:0] x, input logic [31:0] y,
                                             input logic s);
    longint sx, sy;
    sx = s ? longint'($signed(x)) : longint'({32'b0, x});
    sy = s ? longint'($signed(y)) : longint'({32'b0, y});
    return {sx > sy, sx == sy, sx < sy};
  endfunction

  function automatic int model_lat(input logic [31:0] x, input logic [31:0] y);
`ifdef COMPARE_ITER_EARLY_EXIT_EN
    int lead = 0;
    for (int i = NCHUNK - 1; i >= 0; i--) begin
      if (x[i*CHUNK +: CHUNK] != y[i*CHUNK +: CHUNK]) break;
      lead++;
    end
    return ((1 + lead) > NCHUNK ? NCHUNK : (1 + lead)) + 1;
`else
    return NCHUNK + 1;
`endif
  endfunction

  // Checks the result every cycle it is presented.
  always @(negedge clk) begin
    if (!rst && out_valid && cur_valid) begin
      check("flags", {29'b0, AgtB, AeqB, AltB}, {29'b0, cur_exp});
      check("onehot", 32'(AgtB) + 32'(AeqB) + 32'(AltB), 32'd1);
    end
  end

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                        input int hold, input logic lit_en, input logic [2:0] lit_flags,
                        input int lit_lat);
    int n;
    int lat;
    @(negedge clk);
    a = x; b = y; is_signed = s; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    cur_exp   = model_flags(x, y, s);
    cur_valid = 1'b1;
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; is_signed = ~s;
    check("busy_in_ready", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(model_lat(x, y)));
    if (lit_en) begin
      check("lit_flags", {29'b0, AgtB, AeqB, AltB}, {29'b0, lit_flags});
      check("lit_latency", 32'(lat), 32'(lit_lat));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      a = $urandom; b = $urandom;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    cur_valid = 1'b0;
    check("drop_valid", 32'(out_valid), 32'd0);
    check("ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x, y;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_flags", {29'b0, AgtB, AeqB, AltB}, 32'd0);

    run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0, 1'b1, 3'b100, LAT_TOPDIFF);
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0, 1'b1, 3'b001, LAT_TOPDIFF);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 0, 1'b1, 3'b010, 5);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 0, 1'b1, 3'b010, 5);
    run_op(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 0, 1'b1, 3'b001, 5);
    run_op(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 0, 1'b1, 3'b001, 5);
    run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 5, 1'b1, 3'b100, LAT_TOPDIFF);
    run_op(32'h0000_0007, 32'h0000_0009, 1'b0, 0, 1'b1, 3'b001, 5);

    // Reset during the second RUN cycle of a long compare.
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1234_5678; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_flags", {29'b0, AgtB, AeqB, AltB}, 32'd0);
    repeat (6) begin
      @(negedge clk);
      check("abort_hold", 32'(out_valid), 32'd0);
    end
    rst = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    run_op(32'd5, 32'd3, 1'b0, 0, 1'b1, 3'b100, 5);

    for (int k = 0; k < 150; k++) begin
      x = $urandom;
      y = x;
      for (int c = 0; c < NCHUNK; c++) begin
        if ($urandom_range(0, 1) == 1) y[c*CHUNK +: CHUNK] = 8'($urandom);
      end
      run_op(x, y, 1'($urandom), int'($urandom_range(0, 2)), 1'b0, 3'b000, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
